matmul_nxn_stream: RTL and testbench

Parametrised N×N integer matrix multiplier, successor to the fixed 2×2 sequential multiplier in the tiny-tapeout user project.
- Operands A and B stream in row-major through independent valid/ready ports.
- Products are computed with a single time-shared MAC.
- The N×N result streams out row-major through a valid/ready port.
- Adds signed mode, saturation, an overflow flag and output backpressure.

---
 rtl/matmul_nxn_stream_if.sv | 23 ++
 rtl/matmul_nxn_stream.sv | 147 ++++++++++++++
 tb/tb_matmul_nxn_stream.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/matmul_nxn_stream_if.sv
// matmul_nxn_stream_if: A/B operand streams and C result stream, each a valid/ready channel.
interface matmul_nxn_stream_if #(
    parameter int W     = 8,
    parameter int OUT_W = 8
);
    logic [W-1:0]     a_data;
    logic             a_valid;
    logic             a_ready;
    logic [W-1:0]     b_data;
    logic             b_valid;
    logic             b_ready;
    logic [OUT_W-1:0] c_data;
    logic             c_valid;
    logic             c_ready;
    modport master (
        output a_data, a_valid, b_data, b_valid, c_ready,
        input  a_ready, b_ready, c_data, c_valid
    );
    modport slave (
        input  a_data, a_valid, b_data, b_valid, c_ready,
        output a_ready, b_ready, c_data, c_valid
    );
endinterface

// File: rtl/matmul_nxn_stream.sv
// matmul_nxn_stream: NxN integer matrix multiply, one time-shared MAC, streamed A/B in and C out.
// Defining MATMUL_ACC_CHAIN_EN adds acc_keep so a batch can accumulate onto the previous C.
module matmul_nxn_stream #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int OUT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    matmul_nxn_stream_if.slave io,
    input  logic               signed_mode,
    input  logic               sat_mode,
`ifdef MATMUL_ACC_CHAIN_EN
    input  logic               acc_keep,
`endif
    output logic               busy,
    output logic               ovf
);
    localparam int ACC_W = 2 * W + $clog2(N);
    localparam int NN    = N * N;
    localparam int CW    = $clog2(NN + 1);
    localparam int IW    = $clog2(NN);
    localparam int KW    = $clog2(N);
    localparam logic [CW-1:0]    CNT_FULL = CW'(NN);
    localparam logic [KW-1:0]    K_LAST   = KW'(N - 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(NN - 1);
    localparam logic [ACC_W-1:0] UMAX     = {ACC_W{1'b1}} >> (ACC_W - OUT_W);
    localparam logic [ACC_W-1:0] SMAX     = UMAX >> 1;
    localparam logic [ACC_W-1:0] SMIN     = ~SMAX;

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [KW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d, seed, prod;
    logic             sgn_q, sgn_d, sat_q, sat_d, ovf_q, ovf_d;
    logic [W-1:0]     a_q [NN];
    logic [W-1:0]     b_q [NN];
    logic [ACC_W-1:0] c_q [NN];
    logic             a_take, b_take, load_done, c_we, mac_last, c_take;
    logic [IW-1:0]    a_rd, b_rd, c_wr;

    function automatic logic [IW-1:0] at(input logic [KW-1:0] r, input logic [KW-1:0] c);
        return IW'(int'(r) * N + int'(c));
    endfunction

    function automatic logic [ACC_W-1:0] ext(input logic [W-1:0] v, input logic s);
        return {{(ACC_W - W){s & v[W-1]}}, v};
    endfunction

    function automatic logic fits(input logic [ACC_W-1:0] x, input logic s);
        return s ? ($signed(x) <= $signed(SMAX) && $signed(x) >= $signed(SMIN)) : x <= UMAX;
    endfunction

    function automatic logic [OUT_W-1:0] conv(input logic [ACC_W-1:0] x, input logic s, input logic t);
        logic [ACC_W-1:0] y;
        y = (!t || fits(x, s)) ? x : s ? (x[ACC_W-1] ? SMIN : SMAX) : UMAX;
        return y[OUT_W-1:0];
    endfunction

    assign a_take    = io.a_valid && io.a_ready;
    assign b_take    = io.b_valid && io.b_ready;
    assign c_take    = io.c_valid && io.c_ready;
    assign load_done = state_q == LOAD && a_cnt_q + CW'(a_take) == CNT_FULL
                       && b_cnt_q + CW'(b_take) == CNT_FULL;
    assign c_we      = state_q == COMPUTE && k_q == K_LAST;
    assign mac_last  = c_we && i_q == K_LAST && j_q == K_LAST;
    assign a_rd      = at(i_q, k_q);
    assign b_rd      = at(k_q, j_q);
    assign c_wr      = at(i_q, j_q);
    assign prod      = ext(a_q[a_rd], sgn_q) * ext(b_q[b_rd], sgn_q);
    assign acc_d     = (k_q == '0 ? seed : acc_q) + prod;

`ifdef MATMUL_ACC_CHAIN_EN
    logic keep_q;
    always_ff @(posedge clk) keep_q <= rst ? 1'b0 : load_done ? acc_keep : keep_q;
    assign seed = keep_q ? c_q[c_wr] : '0;
`else
    assign seed = '0;
`endif

    always_ff @(posedge clk) state_q <= rst ? LOAD : state_d;

    always_comb begin
        state_d = state_q == LOAD    ? (load_done ? COMPUTE : LOAD)
                : state_q == COMPUTE ? (mac_last ? OUTPUT : COMPUTE)
                : (c_take && idx_q == IDX_LAST) ? LOAD : OUTPUT;
    end

    always_comb begin
        io.a_ready = state_q == LOAD && a_cnt_q != CNT_FULL;
        io.b_ready = state_q == LOAD && b_cnt_q != CNT_FULL;
        io.c_valid = state_q == OUTPUT;
        io.c_data  = state_q == OUTPUT ? conv(c_q[idx_q], sgn_q, sat_q) : '0;
        busy       = state_q != LOAD;
        ovf        = ovf_q;
    end

    // Loop counters wrap to zero at their last value, so a finished batch leaves them ready for the next.
    always_comb begin
        a_cnt_d = load_done ? '0 : a_cnt_q + CW'(a_take);
        b_cnt_d = load_done ? '0 : b_cnt_q + CW'(b_take);
        sgn_d   = load_done ? signed_mode : sgn_q;
        sat_d   = load_done ? sat_mode : sat_q;
        ovf_d   = load_done ? 1'b0 : ovf_q | (c_we && !fits(acc_d, sgn_q));
        k_d     = (state_q != COMPUTE || k_q == K_LAST) ? '0 : k_q + 1'b1;
        j_d     = !c_we ? j_q : j_q == K_LAST ? '0 : j_q + 1'b1;
        i_d     = !(c_we && j_q == K_LAST) ? i_q : i_q == K_LAST ? '0 : i_q + 1'b1;
        idx_d   = !c_take ? idx_q : idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            sgn_q   <= 1'b0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
                c_q[n] <= '0;
            end
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            sgn_q   <= sgn_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
            if (state_q == COMPUTE) acc_q <= acc_d;
            if (a_take) a_q[IW'(a_cnt_q)] <= io.a_data;
            if (b_take) b_q[IW'(b_cnt_q)] <= io.b_data;
            if (c_we) c_q[c_wr] <= acc_d;
        end
    end
endmodule

// File: tb/tb_matmul_nxn_stream.sv
// tb_matmul_nxn_stream: directed and random batches checked against an arithmetic matrix model.
module tb_matmul_nxn_stream;
    localparam int N = 2, W = 8, OUT_W = 8, NN = N * N;

    logic clk = 1'b0, rst = 1'b1, signed_mode = 1'b0, sat_mode = 1'b0, acc_keep = 1'b0;
    logic busy, ovf;
    int checks = 0, errors = 0, cyc = 0, hs_cyc = 0;
    logic [W-1:0] av [NN];
    logic [W-1:0] bv [NN];
    logic [OUT_W-1:0] ec [NN];
    longint prev [NN];
    bit eovf = 1'b0, keep_m = 1'b0;

    matmul_nxn_stream_if #(.W(W), .OUT_W(OUT_W)) io ();

    matmul_nxn_stream #(.N(N), .W(W), .OUT_W(OUT_W)) dut (
        .clk(clk),
        .rst(rst),
        .io(io),
        .signed_mode(signed_mode),
        .sat_mode(sat_mode),
`ifdef MATMUL_ACC_CHAIN_EN
        .acc_keep(acc_keep),
`endif
        .busy(busy),
        .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint val(input logic [W-1:0] x, input bit s);
        return s ? longint'($signed(x)) : longint'(x);
    endfunction

    // Exact integer product, then range-check/clamp/truncate to OUT_W.
    task automatic build_model(input bit s, input bit t);
        longint hi, lo, x;
        hi = s ? (longint'(1) << (OUT_W - 1)) - 1 : (longint'(1) << OUT_W) - 1;
        lo = s ? -(longint'(1) << (OUT_W - 1)) : 0;
        eovf = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                x = keep_m ? prev[r*N+c] : 0;
                for (int k = 0; k < N; k++) x += val(av[r*N+k], s) * val(bv[k*N+c], s);
                prev[r*N+c] = x;
                if (x > hi || x < lo) eovf = 1'b1;
                ec[r*N+c] = OUT_W'((t && x > hi) ? hi : (t && x < lo) ? lo : x);
            end
    endtask

    task automatic feed(input bit gaps, input bit b_first);
        int ai = 0, bi = 0, t = 0;
        bit ta, tb;
        while ((ai < NN || bi < NN) && t < 200) begin
            io.a_valid = ai < NN && (!b_first || bi == NN) && (!gaps || $urandom_range(0, 2) != 0);
            io.a_data  = ai < NN ? av[ai] : '0;
            io.b_valid = bi < NN ? (!gaps || $urandom_range(0, 2) != 0) : b_first;
            io.b_data  = bi < NN ? bv[bi] : W'(99);
            if (bi == NN && b_first) check("b_ready_full", io.b_ready, 1'b0);
            ta = io.a_valid && io.a_ready;
            tb = io.b_valid && io.b_ready;
            @(posedge clk); #1;
            t++;
            if (ta) ai++;
            if (tb) bi++;
        end
        io.a_valid = 1'b0;
        io.b_valid = 1'b0;
        hs_cyc = cyc;
        check("feed_done", 64'(ai + bi), 64'(2 * NN));
    endtask

    task automatic drain(input int stall_at, input int stall_len, input bit chk_lat);
        int got = 0, stalled = 0, t = 0, t0 = 0;
        bit seen = 1'b0;
        while (got < NN && t < 300) begin
            if (io.c_valid && !seen) begin
                seen = 1'b1;
                t0 = t;
                if (chk_lat) check("latency", 64'(cyc - hs_cyc), 64'(8));
            end
            io.c_ready = !(io.c_valid && got == stall_at && stalled < stall_len);
            if (io.c_valid && !io.c_ready) begin
                stalled++;
                check("stall_data", io.c_data, ec[got]);
            end
            if (io.c_valid && io.c_ready) begin
                check($sformatf("c[%0d]", got), io.c_data, ec[got]);
                got++;
            end
            @(posedge clk); #1;
            t++;
        end
        io.c_ready = 1'b1;
        check("drain_done", 64'(got), 64'(NN));
        check("out_cycles", 64'(t - t0), 64'(NN + stall_len));
        check("c_valid_end", io.c_valid, 1'b0);
        check("busy_end", busy, 1'b0);
        check("ovf", ovf, eovf);
    endtask

    task automatic batch(input bit s, input bit t, input bit gaps, input bit b_first,
                         input int stall_at, input int stall_len, input bit chk_lat);
        signed_mode = s;
        sat_mode = t;
        build_model(s, t);
        feed(gaps, b_first);
        signed_mode = ~s;
        sat_mode = ~t;
        check("busy_compute", busy, 1'b1);
        drain(stall_at, stall_len, chk_lat);
    endtask

    initial begin
        io.a_valid = 1'b0;
        io.b_valid = 1'b0;
        io.a_data = '0;
        io.b_data = '0;
        io.c_ready = 1'b1;
        for (int n = 0; n < NN; n++) prev[n] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", io.a_ready, 1'b1);
        check("rst_b_ready", io.b_ready, 1'b1);
        check("rst_c_valid", io.c_valid, 1'b0);
        check("rst_c_data", io.c_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;

        av = '{8'd1, 8'd2, 8'd3, 8'd4};
        bv = '{8'd5, 8'd6, 8'd7, 8'd8};
        batch(0, 0, 0, 0, NN, 0, 1);

        av = '{8'd200, 8'd200, 8'd0, 8'd0};
        bv = '{8'd200, 8'd0, 8'd200, 8'd0};
        batch(0, 0, 1, 0, NN, 0, 0);
        batch(0, 1, 1, 0, NN, 0, 0);

        av = '{8'hFF, 8'd2, 8'd3, 8'hFC};
        bv = '{8'd5, 8'hFA, 8'd7, 8'd8};
        batch(1, 1, 0, 0, NN, 0, 0);
        av = '{8'h80, 8'h80, 8'h80, 8'h80};
        bv = '{8'h80, 8'h80, 8'h80, 8'h80};
        batch(1, 1, 1, 0, NN, 0, 0);

        av = '{8'd1, 8'd2, 8'd3, 8'd4};
        bv = '{8'd5, 8'd6, 8'd7, 8'd8};
        batch(0, 0, 1, 1, 1, 3, 0);

        signed_mode = 1'b0;
        sat_mode = 1'b0;
        feed(0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_c_valid", io.c_valid, 1'b0);
        check("midrst_a_ready", io.a_ready, 1'b1);
        check("midrst_b_ready", io.b_ready, 1'b1);
        for (int n = 0; n < NN; n++) prev[n] = 0;
        batch(0, 0, 0, 0, NN, 0, 1);

        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < NN; n++) begin
                av[n] = W'($urandom);
                bv[n] = W'($urandom);
            end
            batch($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, NN - 1), $urandom_range(0, 3), 0);
        end

`ifdef MATMUL_ACC_CHAIN_EN
        av = '{8'd1, 8'd2, 8'd3, 8'd4};
        bv = '{8'd5, 8'd6, 8'd7, 8'd8};
        keep_m = 1'b0;
        acc_keep = 1'b0;
        batch(0, 0, 0, 0, NN, 0, 0);
        keep_m = 1'b1;
        acc_keep = 1'b1;
        batch(0, 0, 0, 0, NN, 0, 0);
        keep_m = 1'b0;
        acc_keep = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
